// File: rtl/uart_pkg.sv
// Shared definitions for the push-button UART transmitter.
// Holds the FSM state encoding, the parity mode values and the frame data width.
package uart_pkg;

  localparam int DATA_W = 8;

  // Parity modes. Any other value of the PARITY parameter means no parity.
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

endpackage

// File: rtl/uart_tx_trigger_baud_counter.sv
// Bit-period timer for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit period.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - restart the count at 0 on the next edge (frame accept)
//   bit_end   - high during the final cycle of a bit period
module baud_counter #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  assign bit_end = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          cnt <= '0;
    else if (clear)   cnt <= '0;
    else if (bit_end) cnt <= '0;
    else              cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_tx_trigger.sv
// Pulse-triggered UART transmitter: each accepted start pulse sends one latched
// byte as start bit, 8 data bits LSB first, optional parity bit, one stop bit.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   start     - one-cycle send request, honoured only while idle
//   data      - byte to send, sampled only in the accept cycle
//   tx        - serial line, idle high, registered
//   busy      - high from frame accept until frame end
//   done      - one-cycle pulse when the frame ends
module uart_tx_trigger
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam logic PAR_EN  = (PARITY == PAR_EVEN) || (PARITY == PAR_ODD);
  localparam logic PAR_INV = (PARITY == PAR_ODD);

  state_t            state, state_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic [2:0]        idx, idx_n;
  logic              par, par_n;
  logic              accept, bit_end;
  logic              tx_n, busy_n, done_n;

  assign accept = (state == ST_IDLE) && start;

  baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .bit_end (bit_end)
  );

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      shift <= '0;
      idx   <= '0;
      par   <= 1'b0;
      tx    <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      shift <= shift_n;
      idx   <= idx_n;
      par   <= par_n;
      tx    <= tx_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  // Next state. The parity bit is taken from the byte at accept time so later
  // changes on data cannot reach the line.
  always_comb begin
    state_n = state;
    shift_n = shift;
    idx_n   = idx;
    par_n   = par;
    case (state)
      ST_IDLE: if (start) begin
        state_n = ST_START;
        shift_n = data;
        idx_n   = 3'd0;
        par_n   = (^data) ^ PAR_INV;
      end
      ST_START: if (bit_end) state_n = ST_DATA;
      ST_DATA: if (bit_end) begin
        if (idx == 3'd7) begin
          state_n = PAR_EN ? ST_PARITY : ST_STOP;
        end else begin
          shift_n = {1'b0, shift[DATA_W-1:1]};
          idx_n   = idx + 3'd1;
        end
      end
      ST_PARITY: if (bit_end) state_n = ST_STOP;
      ST_STOP:   if (bit_end) state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // Outputs decoded from the upcoming state so they land in flops together
  // with the state itself.
  always_comb begin
    tx_n   = 1'b1;
    busy_n = (state_n != ST_IDLE);
    done_n = (state == ST_STOP) && bit_end;
    case (state_n)
      ST_START:  tx_n = 1'b0;
      ST_DATA:   tx_n = shift_n[0];
      ST_PARITY: tx_n = par_n;
      default:   tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_trigger.sv
// Directed bench for uart_tx_trigger with CLKS_PER_BIT=4 and all three parity modes.
module tb_uart_tx_trigger;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic [2:0] st = 3'b000;
  logic [2:0] tx, busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_trigger #(.CLKS_PER_BIT(C), .PARITY(0)) dut0 (
    .clk(clk), .rst(rst), .start(st[0]), .data(data), .tx(tx[0]), .busy(busy[0]), .done(done[0]));
  uart_tx_trigger #(.CLKS_PER_BIT(C), .PARITY(1)) dut1 (
    .clk(clk), .rst(rst), .start(st[1]), .data(data), .tx(tx[1]), .busy(busy[1]), .done(done[1]));
  uart_tx_trigger #(.CLKS_PER_BIT(C), .PARITY(2)) dut2 (
    .clk(clk), .rst(rst), .start(st[2]), .data(data), .tx(tx[2]), .busy(busy[2]), .done(done[2]));

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_chk(input string tag, input int sel);
    chk({tag, "_tx"},   tx[sel],   1'b1);
    chk({tag, "_busy"}, busy[sel], 1'b0);
    chk({tag, "_done"}, done[sel], 1'b0);
  endtask

  // One full frame on DUT sel. Expected bit sequence is built from b and pm.
  // poke: frame cycle at which a stray start with 8'hFF is pulsed (-1 = none).
  // arm: request the next frame (byte nb) in the done cycle.
  // preset: start/data already set up by the caller for the accept edge.
  task automatic frame(input int sel, input logic [7:0] b, input int pm, input int poke,
                       input logic arm, input logic [7:0] nb, input logic preset);
    logic [10:0] seq;
    int nbits;
    seq = '1;
    seq[0] = 1'b0;
    for (int i = 0; i < 8; i++) seq[1+i] = b[i];
    nbits = 10;
    if (pm != 0) begin
      seq[9] = (^b) ^ (pm == 2);
      nbits  = 11;
    end
    if (!preset) begin
      @(negedge clk);
      st[sel] = 1'b1;
      data    = b;
    end
    @(posedge clk);
    for (int j = 0; j < nbits * C; j++) begin
      @(negedge clk);
      if (j == poke) begin
        st[sel] = 1'b1;
        data    = 8'hFF;
      end else begin
        st[sel] = 1'b0;
        data    = data ^ 8'h5A;
      end
      chk($sformatf("frm%0d_%h_c%0d_tx", sel, b, j), tx[sel], seq[j / C]);
      chk($sformatf("frm%0d_%h_c%0d_busy", sel, b, j), busy[sel], 1'b1);
      chk($sformatf("frm%0d_%h_c%0d_done", sel, b, j), done[sel], 1'b0);
    end
    @(negedge clk);
    chk($sformatf("end%0d_%h_done", sel, b), done[sel], 1'b1);
    chk($sformatf("end%0d_%h_busy", sel, b), busy[sel], 1'b0);
    chk($sformatf("end%0d_%h_tx", sel, b), tx[sel], 1'b1);
    if (arm) begin
      st[sel] = 1'b1;
      data    = nb;
    end else begin
      st[sel] = 1'b0;
      @(negedge clk);
      idle_chk($sformatf("post%0d_%h", sel, b), sel);
    end
  endtask

  initial begin
    // Reset held with start toggling: everything stays idle.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      st   = (i % 2 == 0) ? 3'b111 : 3'b000;
      data = 8'hA5;
      for (int s = 0; s < 3; s++) idle_chk($sformatf("rst%0d_dut%0d", i, s), s);
    end
    @(negedge clk);
    st  = 3'b000;
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) idle_chk($sformatf("rel_dut%0d", s), s);

    // Basic frame, no parity
    frame(0, 8'hA5, 0, -1, 1'b0, 8'h00, 1'b0);
    // Even and odd parity on 8'h07
    frame(1, 8'h07, 1, -1, 1'b0, 8'h00, 1'b0);
    frame(2, 8'h07, 2, -1, 1'b0, 8'h00, 1'b0);

    // Busy rejection: stray start at cycle 10 is not honoured or queued
    frame(0, 8'h55, 0, 9, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idle_chk($sformatf("noq%0d", i), 0);
    end

    // Back-to-back: second request in the done cycle
    frame(0, 8'hC3, 0, -1, 1'b1, 8'h3C, 1'b0);
    frame(0, 8'h3C, 0, -1, 1'b0, 8'h00, 1'b1);

    // Mid-frame reset at cycle 18 (data bit 3 of 8'hF0 is 0 on the line)
    @(negedge clk);
    st[0] = 1'b1;
    data  = 8'hF0;
    @(posedge clk);
    for (int j = 0; j < 18; j++) begin
      @(negedge clk);
      st[0] = 1'b0;
    end
    chk("mid_tx_before", tx[0], 1'b0);
    chk("mid_busy_before", busy[0], 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_tx_async", tx[0], 1'b1);
    chk("mid_busy_async", busy[0], 1'b0);
    chk("mid_done_async", done[0], 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_chk($sformatf("midrst%0d", i), 0);
    end
    // Release reset with start already high: accepted at the first edge.
    rst   = 1'b0;
    st[0] = 1'b1;
    data  = 8'h81;
    frame(0, 8'h81, 0, -1, 1'b0, 8'h00, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_trigger.md
# uart_tx_trigger

Pulse-triggered UART transmitter that consumes the debouncer's single-cycle `one_shot` output and serialises one latched byte per pulse onto the `tx` line (8 data bits, LSB first, optional parity, 1 stop bit). It sits between the push-button front end and the board TX pin. It gives the RISC-V single-cycle/UART system a manual "send byte" path, with status flags usable by the core or by LEDs.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per bit (50 MHz / 115200); legal range ≥ 2.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd; any other value behaves as 0.
- `clk`  input  1  system clock; all state changes on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  one-cycle trigger (debouncer `one_shot`); a level held high is treated as one request per accepted frame.
- `data`  input  8  byte to send; sampled only in the cycle `start` is accepted.
- `tx`  output  1  serial line, idle high.
- `busy`  output  1  high from frame acceptance until frame end.
- `done`  output  1  one-cycle pulse at frame end.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: `tx`=1, `busy`=0. When `start`=1, latch `data` into the shift register, clear the baud counter and bit index, and go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: `tx`=shift[0] for CLKS_PER_BIT cycles per bit, then shift right. The bit index runs 0..7.
  - After bit 7, go to PARITY if PARITY∈{1,2}; otherwise go to STOP.
- PARITY: `tx` = XOR of the latched byte (even), or its inverse (odd), for CLKS_PER_BIT cycles, then go to STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles, then go to IDLE with `done`=1 for that one cycle.
- Parity is computed from the latched copy, never from live `data`.
- `start` outside IDLE is ignored and not queued. Changes on `data` outside the accept cycle have no effect.
- Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 on the bit-end cycle. The bit index is 3 bits; it advances only on bit-end cycles in DATA.
- All outputs are registered, so `tx` is glitch-free.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, `tx`=1, `busy`=0, `done`=0, counters=0, shift register=0.
- Reset mid-frame aborts the frame: `tx` returns high without waiting for a clock. No `done` is produced.
- Let edge k be the rising edge where `start`=1 is sampled in IDLE:
  - `tx` falls and `busy` rises at edge k.
  - Data bit i is driven from edge k+(1+i)·CLKS_PER_BIT.
  - The parity bit, if enabled, is driven from edge k+9·CLKS_PER_BIT.
  - The stop bit is driven from edge k+(9+P)·CLKS_PER_BIT, where P=1 with parity and 0 without.
- At edge k+(10+P)·CLKS_PER_BIT: `busy` falls, `done` rises for one cycle, and the state is IDLE.
- The earliest next acceptance is the edge after `done`. The minimum inter-frame gap is therefore the stop bit plus one cycle.
- `start` coincident with the `done` cycle is accepted at the following edge (back-to-back frames).
- `start` coincident with reset deassertion is accepted if rst is low at that edge.

## Structure
- Shared package/header `uart_pkg`: state encodings (3-bit: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4), parity mode constants (PAR_NONE/PAR_EVEN/PAR_ODD), frame data width 8.
- One sub-module `baud_counter`:
  - Parameter CLKS_PER_BIT.
  - Ports: `clk`, `rst`, `clear`, `bit_end` pulse.
  - The top instantiates it and pulses `clear` on frame accept.
  - The FSM, shift register and parity logic stay in the top.

## Test plan
- Reset check: drive rst=1 with `start` toggling → `tx`=1, `busy`=0, `done`=0 throughout.
- Basic frame, CLKS_PER_BIT=4, PARITY=0: pulse `start` with `data`=8'hA5.
  - `tx` sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1.
  - `done` pulses exactly 40 cycles after acceptance; `busy` is high for 40 cycles.
- Parity: `data`=8'h07 with PARITY=1 → parity bit 1; with PARITY=2 → parity bit 0. Frame length is 44 cycles.
- Busy rejection: pulse `start` (`data`=8'h55), then pulse again at cycle 10 with `data`=8'hFF.
  - Only 8'h55 is transmitted and only one `done` appears.
  - `data` changes after acceptance do not alter bits.
- Back-to-back: assert `start` in the `done` cycle with `data`=8'h3C → the second frame's start bit begins on the next edge and 8'h3C is transmitted correctly.
- Mid-frame reset: assert rst at cycle 18 of a frame → `tx`=1 and `busy`=0 immediately, no `done`. After release, a new `start` with 8'h81 transmits a clean frame.
